id2ex_stage: RTL and testbench
==============================

# id2ex_stage

ID/EX pipeline register of the in-order pipeline, with load-use hazard detection and bubble insertion. Captures decoded operands and control from ID and presents them to EX one cycle later. Consumes the ID-stage forwarding selects: when ID wants a result from the instruction in id2ex and that instruction is a load, ID is stalled one cycle and a bubble is inserted. Its `rd` index/enable outputs feed the forwarding unit's id2ex inputs.

## Interface
- `XLEN`, 64, datapath width
- `REG_INDEX_SIZE`, 5, register index width
- `ALU_OP_W`, 6, ALU opcode width
---
- `id2ex_clk_i`  in  1  clock, rising edge
- `id2ex_rst_n_i`  in  1  reset, asynchronous, active-low
- `id2ex_id_valid_i`  in  1  ID holds a valid instruction
- `id2ex_id_pc_i`  in  XLEN  instruction PC
- `id2ex_id_rs1_data_i` / `id2ex_id_rs2_data_i`  in  XLEN  operands after ID forwarding mux
- `id2ex_id_imm_i`  in  XLEN  immediate
- `id2ex_id_alu_op_i`  in  ALU_OP_W  ALU operation
- `id2ex_id_rd_index_i`  in  REG_INDEX_SIZE  destination register
- `id2ex_id_rd_en_i`  in  1  instruction writes rd
- `id2ex_id_mem_read_i` / `id2ex_id_mem_write_i`  in  1  load / store
- `id2ex_id_rs1_src_id2ex_i` / `id2ex_id_rs2_src_id2ex_i`  in  1  forwarding unit selects id2ex for rs1 / rs2
- `id2ex_ex_ready_i`  in  1  EX accepts the current id2ex contents this cycle
- `id2ex_flush_i`  in  1  kill the instruction being captured (branch/jump redirect)
- `id2ex_id_stall_o`  out  1  ID must hold its instruction
- `id2ex_valid_o`  out  1  id2ex holds a valid instruction
- `id2ex_pc_o`, `id2ex_rs1_data_o`, `id2ex_rs2_data_o`, `id2ex_imm_o`  out  XLEN  registered copies
- `id2ex_alu_op_o`  out  ALU_OP_W  registered ALU op
- `id2ex_rd_index_o`  out  REG_INDEX_SIZE  registered rd
- `id2ex_rd_en_o`, `id2ex_mem_read_o`, `id2ex_mem_write_o`  out  1  registered control, always 0 when `id2ex_valid_o`=0
- `id2ex_lu_bubble_cnt_o`  out  32  load-use bubble count (see Configuration)

## Operation
- `load_use` = `id_valid_i` & `valid_o` & `mem_read_o` & (`rs1_src_id2ex_i` | `rs2_src_id2ex_i`).
- `hold` = `valid_o` & ~`ex_ready_i`.
- `id_stall_o` = `hold` | `load_use` (combinational).
- Register update at each rising edge, priority highest first:
  1. `flush_i`=1: `valid`, `rd_en`, `mem_read`, `mem_write` <- 0. Data fields don't care. Flush overrides `hold`.
  2. `hold`: all fields keep their values.
  3. `load_use`: insert bubble. `valid`, `rd_en`, `mem_read`, `mem_write` <- 0. ID holds, so the same instruction re-evaluates next cycle against a non-load id2ex.
  4. Otherwise capture all ID inputs. Control bits are ANDed with `id_valid_i`, so an invalid ID entry becomes a bubble.
- Outputs are pure register outputs. No combinational path from inputs to data outputs.
- An rs match against id2ex where id2ex is a non-load does not stall. EX forwards the result.
- `rd_index` = 0 needs no special handling here; the forwarding unit already masks x0.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): every registered output is 0, including `pc`, data, `alu_op`, `rd_index` and the counter. `id_stall_o` is therefore 0 while in reset.
- Latency: ID inputs appear on outputs one cycle after capture.
- Load-use costs exactly one bubble cycle. On the cycle after the bubble, `load_use` is 0 because id2ex is invalid.
- `load_use` and `hold` together: `hold` wins, nothing is captured, and `id_stall_o`=1.
- `flush_i` and `load_use` together: flush wins. `id_stall_o` still follows its equation; the redirect logic upstream discards ID.
- Reset asserted mid-stall: the register is cleared immediately and any in-flight instruction is lost.

## Configuration
- `ID2EX_PERF_CNT_EN` defined:
  - 32-bit counter increments on every edge where a load-use bubble is inserted (case 3 taken).
  - Saturates at 0xFFFF_FFFF.
  - Cleared only by reset.
  - Drives `id2ex_lu_bubble_cnt_o`.
- Not defined: no counter flops; `id2ex_lu_bubble_cnt_o` tied to 0.

## Test plan
- Reset then capture: deassert reset, present valid `pc`=0x8000_0000, `rd`=5, `rd_en`=1, `ex_ready`=1 -> next cycle `valid_o`=1, `pc_o`=0x8000_0000, `rd_index_o`=5, `id_stall_o`=0.
- Load-use: id2ex holds load `rd`=7 (`mem_read_o`=1), ID valid with `rs1_src_id2ex_i`=1 -> `id_stall_o`=1 that cycle. Next cycle `valid_o`=0, `rd_en_o`=0, `id_stall_o`=0. Following cycle captures the ID instruction. Counter = 1 with `ID2EX_PERF_CNT_EN`.
- Non-load match: id2ex holds ALU op `rd`=7, ID `rs2_src_id2ex_i`=1 -> `id_stall_o`=0 and capture on the next edge.
- EX backpressure: `valid_o`=1, `ex_ready_i`=0 for 3 cycles -> outputs stable for 3 cycles and `id_stall_o`=1 throughout. Capture occurs on the edge after `ex_ready_i` returns to 1.
- Flush priority: `flush_i`=1 together with `ex_ready_i`=0 and `load_use`=1 -> next cycle `valid_o`=0, `rd_en_o`=0, `mem_read_o`=0, `mem_write_o`=0. The counter does not increment.
- Async reset mid-operation: assert `rst_n` low between clock edges while `valid_o`=1 -> all outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id2ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Captures decoded operands and control from ID and presents them to EX one
// cycle later. A dependent instruction directly behind a load stalls ID for one
// cycle, and a bubble goes into EX in its place.
// Optional feature macro: ID2EX_PERF_CNT_EN adds a saturating 32-bit counter of
// load-use bubbles. Without it the counter output is tied to zero.
module id2ex_stage #(
    parameter int XLEN           = 64,
    parameter int REG_INDEX_SIZE = 5,
    parameter int ALU_OP_W       = 6
) (
    input  logic                      id2ex_clk_i,
    input  logic                      id2ex_rst_n_i,
    input  logic                      id2ex_id_valid_i,
    input  logic [XLEN-1:0]           id2ex_id_pc_i,
    input  logic [XLEN-1:0]           id2ex_id_rs1_data_i,
    input  logic [XLEN-1:0]           id2ex_id_rs2_data_i,
    input  logic [XLEN-1:0]           id2ex_id_imm_i,
    input  logic [ALU_OP_W-1:0]       id2ex_id_alu_op_i,
    input  logic [REG_INDEX_SIZE-1:0] id2ex_id_rd_index_i,
    input  logic                      id2ex_id_rd_en_i,
    input  logic                      id2ex_id_mem_read_i,
    input  logic                      id2ex_id_mem_write_i,
    input  logic                      id2ex_id_rs1_src_id2ex_i,
    input  logic                      id2ex_id_rs2_src_id2ex_i,
    input  logic                      id2ex_ex_ready_i,
    input  logic                      id2ex_flush_i,
    output logic                      id2ex_id_stall_o,
    output logic                      id2ex_valid_o,
    output logic [XLEN-1:0]           id2ex_pc_o,
    output logic [XLEN-1:0]           id2ex_rs1_data_o,
    output logic [XLEN-1:0]           id2ex_rs2_data_o,
    output logic [XLEN-1:0]           id2ex_imm_o,
    output logic [ALU_OP_W-1:0]       id2ex_alu_op_o,
    output logic [REG_INDEX_SIZE-1:0] id2ex_rd_index_o,
    output logic                      id2ex_rd_en_o,
    output logic                      id2ex_mem_read_o,
    output logic                      id2ex_mem_write_o,
    output logic [31:0]               id2ex_lu_bubble_cnt_o
);

    logic                      valid_q, valid_d;
    logic [XLEN-1:0]           pc_q, pc_d;
    logic [XLEN-1:0]           rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]           rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]           imm_q, imm_d;
    logic [ALU_OP_W-1:0]       alu_op_q, alu_op_d;
    logic [REG_INDEX_SIZE-1:0] rd_index_q, rd_index_d;
    logic                      rd_en_q, rd_en_d;
    logic                      mem_read_q, mem_read_d;
    logic                      mem_write_q, mem_write_d;

    logic load_use;
    logic hold;
    logic bubble_take;

    // A load in id2ex cannot forward until MEM, so a consumer directly behind it
    // waits one cycle. EX backpressure freezes the register entirely.
    assign load_use = id2ex_id_valid_i & valid_q & mem_read_q &
                      (id2ex_id_rs1_src_id2ex_i | id2ex_id_rs2_src_id2ex_i);
    assign hold     = valid_q & ~id2ex_ex_ready_i;
    assign id2ex_id_stall_o = hold | load_use;

    // The bubble is counted only when it is actually inserted. Flush and hold
    // both take precedence over it.
    assign bubble_take = ~id2ex_flush_i & ~hold & load_use;

    // Next-state selection. Priority: flush, hold, load-use bubble, capture.
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        alu_op_d    = alu_op_q;
        rd_index_d  = rd_index_q;
        rd_en_d     = rd_en_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        if (id2ex_flush_i || (!hold && load_use)) begin
            // Flush and bubble both kill the control bits. Data fields are
            // meaningless once valid is low, so they keep their old values.
            valid_d     = 1'b0;
            rd_en_d     = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else if (!hold) begin
            // An invalid ID entry turns into a bubble with all control bits clear.
            valid_d     = id2ex_id_valid_i;
            pc_d        = id2ex_id_pc_i;
            rs1_data_d  = id2ex_id_rs1_data_i;
            rs2_data_d  = id2ex_id_rs2_data_i;
            imm_d       = id2ex_id_imm_i;
            alu_op_d    = id2ex_id_alu_op_i;
            rd_index_d  = id2ex_id_rd_index_i;
            rd_en_d     = id2ex_id_rd_en_i & id2ex_id_valid_i;
            mem_read_d  = id2ex_id_mem_read_i & id2ex_id_valid_i;
            mem_write_d = id2ex_id_mem_write_i & id2ex_id_valid_i;
        end
    end

    // Pipeline register. Reset clears every field, including the data fields.
    always_ff @(posedge id2ex_clk_i or negedge id2ex_rst_n_i) begin
        if (!id2ex_rst_n_i) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            alu_op_q    <= '0;
            rd_index_q  <= '0;
            rd_en_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            alu_op_q    <= alu_op_d;
            rd_index_q  <= rd_index_d;
            rd_en_q     <= rd_en_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign id2ex_valid_o     = valid_q;
    assign id2ex_pc_o        = pc_q;
    assign id2ex_rs1_data_o  = rs1_data_q;
    assign id2ex_rs2_data_o  = rs2_data_q;
    assign id2ex_imm_o       = imm_q;
    assign id2ex_alu_op_o    = alu_op_q;
    assign id2ex_rd_index_o  = rd_index_q;
    assign id2ex_rd_en_o     = rd_en_q;
    assign id2ex_mem_read_o  = mem_read_q;
    assign id2ex_mem_write_o = mem_write_q;

`ifdef ID2EX_PERF_CNT_EN
    logic [31:0] lu_cnt_q, lu_cnt_d;

    // Saturating count of inserted load-use bubbles.
    always_comb begin
        lu_cnt_d = lu_cnt_q;
        if (bubble_take && (lu_cnt_q != 32'hFFFF_FFFF)) begin
            lu_cnt_d = lu_cnt_q + 32'd1;
        end
    end

    // The counter is cleared only by reset.
    always_ff @(posedge id2ex_clk_i or negedge id2ex_rst_n_i) begin
        if (!id2ex_rst_n_i) begin
            lu_cnt_q <= '0;
        end else begin
            lu_cnt_q <= lu_cnt_d;
        end
    end

    assign id2ex_lu_bubble_cnt_o = lu_cnt_q;
`else
    logic unused_bubble_take;
    assign unused_bubble_take    = bubble_take;
    assign id2ex_lu_bubble_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_id2ex_stage.sv
// Testbench for id2ex_stage. A behavioural model of the stage's contents is
// compared against the DUT on every falling clock edge. Directed scenarios
// also check literal expected values, followed by a randomized run.
module tb_id2ex_stage;

    localparam int XLEN = 64;
    localparam int RW   = 5;
    localparam int AW   = 6;

    logic            clk;
    logic            rst_n;
    logic            id_valid;
    logic [XLEN-1:0] id_pc, id_rs1, id_rs2, id_imm;
    logic [AW-1:0]   id_alu;
    logic [RW-1:0]   id_rd;
    logic            id_rd_en, id_mr, id_mw, s1, s2, ex_ready, flush;

    logic            stall_o, valid_o, rd_en_o, mr_o, mw_o;
    logic [XLEN-1:0] pc_o, rs1_o, rs2_o, imm_o;
    logic [AW-1:0]   alu_o;
    logic [RW-1:0]   rd_o;
    logic [31:0]     cnt_o;

    int tests = 0;
    int fails = 0;
    bit check_en = 0;

    id2ex_stage #(.XLEN(XLEN), .REG_INDEX_SIZE(RW), .ALU_OP_W(AW)) dut (
        .id2ex_clk_i              (clk),
        .id2ex_rst_n_i            (rst_n),
        .id2ex_id_valid_i         (id_valid),
        .id2ex_id_pc_i            (id_pc),
        .id2ex_id_rs1_data_i      (id_rs1),
        .id2ex_id_rs2_data_i      (id_rs2),
        .id2ex_id_imm_i           (id_imm),
        .id2ex_id_alu_op_i        (id_alu),
        .id2ex_id_rd_index_i      (id_rd),
        .id2ex_id_rd_en_i         (id_rd_en),
        .id2ex_id_mem_read_i      (id_mr),
        .id2ex_id_mem_write_i     (id_mw),
        .id2ex_id_rs1_src_id2ex_i (s1),
        .id2ex_id_rs2_src_id2ex_i (s2),
        .id2ex_ex_ready_i         (ex_ready),
        .id2ex_flush_i            (flush),
        .id2ex_id_stall_o         (stall_o),
        .id2ex_valid_o            (valid_o),
        .id2ex_pc_o               (pc_o),
        .id2ex_rs1_data_o         (rs1_o),
        .id2ex_rs2_data_o         (rs2_o),
        .id2ex_imm_o              (imm_o),
        .id2ex_alu_op_o           (alu_o),
        .id2ex_rd_index_o         (rd_o),
        .id2ex_rd_en_o            (rd_en_o),
        .id2ex_mem_read_o         (mr_o),
        .id2ex_mem_write_o        (mw_o),
        .id2ex_lu_bubble_cnt_o    (cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The instruction currently sitting in the stage, as the pipeline sees it.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc, rs1, rs2, imm;
        logic [AW-1:0]   alu;
        logic [RW-1:0]   rd;
        logic            rd_en, mr, mw;
    } instr_t;

    instr_t      m;
    logic [31:0] m_cnt;
    initial begin
        m     = '0;
        m_cnt = '0;
    end

    function automatic logic model_load_use();
        return id_valid && m.valid && m.mr && (s1 || s2);
    endfunction

    function automatic logic model_stalled();
        return (m.valid && !ex_ready) || model_load_use();
    endfunction

    function automatic logic [31:0] exp_cnt();
`ifdef ID2EX_PERF_CNT_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a flushed or bubbled stage holds nothing; a stage that EX has not
    // taken stays put; otherwise the stage receives whatever ID offers.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m     = '0;
            m_cnt = '0;
        end else if (flush) begin
            m.valid = 0; m.rd_en = 0; m.mr = 0; m.mw = 0;
        end else if (m.valid && !ex_ready) begin
            // EX still busy with the current instruction
        end else if (model_load_use()) begin
            m.valid = 0; m.rd_en = 0; m.mr = 0; m.mw = 0;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end else begin
            m.valid = id_valid;
            m.pc    = id_pc;
            m.rs1   = id_rs1;
            m.rs2   = id_rs2;
            m.imm   = id_imm;
            m.alu   = id_alu;
            m.rd    = id_rd;
            m.rd_en = id_valid && id_rd_en;
            m.mr    = id_valid && id_mr;
            m.mw    = id_valid && id_mw;
        end
    end

    // Per-cycle comparison against the model. Data fields are meaningful only
    // while the stage holds a valid instruction.
    always @(negedge clk) begin
        if (check_en) begin
            check("valid", valid_o, m.valid);
            check("rd_en", rd_en_o, m.rd_en);
            check("mem_read", mr_o, m.mr);
            check("mem_write", mw_o, m.mw);
            check("stall", stall_o, model_stalled());
            check("cnt", cnt_o, exp_cnt());
            if (m.valid) begin
                check("pc", pc_o, m.pc);
                check("rs1", rs1_o, m.rs1);
                check("rs2", rs2_o, m.rs2);
                check("imm", imm_o, m.imm);
                check("alu", alu_o, m.alu);
                check("rd", rd_o, m.rd);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_imm = '0;
        id_alu = '0; id_rd = '0; id_rd_en = 0; id_mr = 0; id_mw = 0;
        s1 = 0; s2 = 0; ex_ready = 1; flush = 0;
    endtask

    task automatic offer(input logic [63:0] pc, input logic [4:0] rd, input logic ld);
        id_valid = 1; id_pc = pc; id_rd = rd; id_rd_en = 1; id_mr = ld; id_mw = 0;
        id_rs1 = pc ^ 64'h1111; id_rs2 = pc ^ 64'h2222; id_imm = pc + 4; id_alu = pc[5:0];
        s1 = 0; s2 = 0;
    endtask

    logic [31:0] cnt_after_lu;

    initial begin
        rst_n = 0;
        idle();
        repeat (3) cyc();
        check("reset_valid", valid_o, 0);
        check("reset_pc", pc_o, 0);
        check("reset_stall", stall_o, 0);
        check("reset_cnt", cnt_o, 0);
        rst_n = 1;
        check_en = 1;

        // Capture after reset
        offer(64'h8000_0000, 5'd5, 0);
        cyc();
        idle();
        #1;
        check("cap_valid", valid_o, 1);
        check("cap_pc", pc_o, 64'h8000_0000);
        check("cap_rd", rd_o, 5);
        check("cap_stall", stall_o, 0);

        // Load-use: a load at rd=7, then a consumer of it through rs1
        offer(64'h100, 5'd7, 1);
        cyc();
        offer(64'h104, 5'd8, 0);
        s1 = 1;
        #1;
        check("lu_stall", stall_o, 1);
        cyc();
        check("lu_bubble_valid", valid_o, 0);
        check("lu_bubble_rd_en", rd_en_o, 0);
        check("lu_bubble_stall", stall_o, 0);
        cyc();
        check("lu_cap_valid", valid_o, 1);
        check("lu_cap_pc", pc_o, 64'h104);
        check("lu_cap_rd", rd_o, 8);
`ifdef ID2EX_PERF_CNT_EN
        cnt_after_lu = 32'd1;
`else
        cnt_after_lu = 32'd0;
`endif
        check("lu_cnt", cnt_o, cnt_after_lu);

        // Non-load match: forwarding from an ALU op must not stall
        offer(64'h108, 5'd9, 0);
        s2 = 1;
        #1;
        check("nl_stall", stall_o, 0);
        cyc();
        check("nl_cap_pc", pc_o, 64'h108);

        // EX backpressure for three cycles
        offer(64'h10C, 5'd10, 0);
        ex_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_stall", stall_o, 1);
            cyc();
            check("bp_hold_pc", pc_o, 64'h108);
            check("bp_hold_valid", valid_o, 1);
        end
        ex_ready = 1;
        cyc();
        check("bp_cap_pc", pc_o, 64'h10C);

        // Flush together with hold and load-use
        offer(64'h200, 5'd11, 1);
        cyc();
        offer(64'h204, 5'd12, 0);
        s1 = 1; ex_ready = 0; flush = 1;
        #1;
        check("fl_stall", stall_o, 1);
        cyc();
        idle();
        check("fl_valid", valid_o, 0);
        check("fl_rd_en", rd_en_o, 0);
        check("fl_mem_read", mr_o, 0);
        check("fl_mem_write", mw_o, 0);
        check("fl_cnt", cnt_o, cnt_after_lu);

        // Asynchronous reset between edges
        offer(64'h300, 5'd13, 1);
        id_mw = 1;
        cyc();
        idle();
        check("ar_pre_valid", valid_o, 1);
        #2;
        rst_n = 0;
        #1;
        check("ar_valid", valid_o, 0);
        check("ar_pc", pc_o, 0);
        check("ar_rs1", rs1_o, 0);
        check("ar_imm", imm_o, 0);
        check("ar_alu", alu_o, 0);
        check("ar_rd", rd_o, 0);
        check("ar_ctrl", {rd_en_o, mr_o, mw_o}, 0);
        check("ar_cnt", cnt_o, 0);
        check("ar_stall", stall_o, 0);
        cyc();
        rst_n = 1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            id_valid = ($urandom_range(0, 9) < 8);
            id_pc    = {$urandom, $urandom};
            id_rs1   = {$urandom, $urandom};
            id_rs2   = {$urandom, $urandom};
            id_imm   = {$urandom, $urandom};
            id_alu   = AW'($urandom);
            id_rd    = RW'($urandom);
            id_rd_en = $urandom_range(0, 1);
            id_mr    = ($urandom_range(0, 9) < 4);
            id_mw    = ($urandom_range(0, 9) < 2);
            s1       = ($urandom_range(0, 9) < 3);
            s2       = ($urandom_range(0, 9) < 3);
            ex_ready = ($urandom_range(0, 9) < 8);
            flush    = ($urandom_range(0, 19) == 0);
            cyc();
        end

        idle();
        cyc();
        check_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
